// File: rtl/mvs_pkg.sv
// Shared types and slicing helpers for the 3x3 matrix-vector sequencer.
package mvs_pkg;

    localparam int ELEM_W = 16;
    localparam int DIM    = 3;

    typedef logic signed [ELEM_W-1:0] elem_t;

    // Ascending packed range: element 0 sits at the MSBs, matching the bus order.
    typedef elem_t [0:DIM-1] row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row r of a row-major 144-bit matrix; row 0 occupies [143:96].
    function automatic row_t mat_row(input logic [DIM*DIM*ELEM_W-1:0] m,
                                     input logic [1:0] r);
        row_t v;
        case (r)
            2'd0:    v = m[143:96];
            2'd1:    v = m[95:48];
            2'd2:    v = m[47:0];
            default: v = '0;
        endcase
        return v;
    endfunction

    // Element i of a row; element 0 at the MSBs.
    function automatic elem_t row_elem(input row_t v, input int i);
        return v[i];
    endfunction

endpackage

// File: rtl/mvs_dot3.sv
// Combinational 3-element dot product, truncated to 16 bits with wrapping adds.
module mvs_dot3
    import mvs_pkg::*;
(
    input  row_t  a,
    input  row_t  b,
    output elem_t y
);

    elem_t [0:DIM-1] prod;

    // Each product keeps only its low 16 bits; the sum wraps modulo 2^16.
    always_comb begin
        prod = '0;
        for (int i = 0; i < DIM; i++) begin
            prod[i] = row_elem(a, i) * row_elem(b, i);
        end
        y = prod[0] + prod[1] + prod[2];
    end

endmodule

// File: rtl/matrix_vector_sequencer.sv
// Time-multiplexes one dot3 unit over the three matrix rows, one row per clock.
module matrix_vector_sequencer
    import mvs_pkg::*;
(
    input  logic         system1000,
    input  logic         system1000_rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [143:0] in_matrix,
    input  logic [47:0]  in_vector,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [47:0]  out_data,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [1:0]   row_q, row_d;
    logic         load_ops;
    logic         wr_row;
    logic [143:0] mat_q;
    row_t         vec_q;
    row_t         res_q;
    row_t         sel_row;
    elem_t        dot_y;

    assign sel_row = mat_row(mat_q, row_q);

    mvs_dot3 u_dot (
        .a (sel_row),
        .b (vec_q),
        .y (dot_y)
    );

    // State and row counter; row_q only ever holds 0..2.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= IDLE;
            row_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Next-state, acceptance and row-write decode.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        load_ops = 1'b0;
        wr_row   = 1'b0;
        in_ready = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_ops = 1'b1;
                    row_d    = 2'd0;
                    state_d  = ROW;
                end
            end
            ROW: begin
                wr_row = 1'b1;
                if (row_q == 2'd2) begin
                    row_d   = 2'd0;
                    state_d = DONE;
                end else begin
                    row_d = 2'(row_q + 2'd1);
                end
            end
            DONE: begin
                // Consumer handshake doubles as the next acceptance slot.
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load_ops = 1'b1;
                        row_d    = 2'd0;
                        state_d  = ROW;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operands are sampled only at acceptance.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            mat_q <= '0;
            vec_q <= '0;
        end else if (load_ops) begin
            mat_q <= in_matrix;
            vec_q <= in_vector;
        end
    end

    // One result register written per ROW cycle, selected by the row counter.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            res_q <= '0;
        end else if (wr_row) begin
            for (int i = 0; i < DIM; i++) begin
                if (row_q == i[1:0]) res_q[i] <= dot_y;
            end
        end
    end

    assign out_data  = res_q;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROW);

endmodule

// File: doc/matrix_vector_sequencer.md
# matrix_vector_sequencer

Sequences a single shared 3-element dot-product unit over the three rows of a 3x3 signed 16-bit matrix, producing the full matrix-vector product. Operands are accepted on a valid/ready input channel and results are presented on a valid/ready output channel. One result row is computed per clock. The block sits between the register-mapped matrix/vector source and the downstream consumer in the MatrixMultiplyCore3x3 path.

## Interface
- No parameters: element width 16, dimension 3, both fixed.
- system1000  in  1  clock
- system1000_rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand set available
- in_ready  out  1  block can accept operands this cycle
- in_matrix  in  144  row-major; row 0 at [143:96], row 1 at [95:48], row 2 at [47:0]; within a row, element 0 at the MSBs
- in_vector  in  48  element 0 at [47:32], element 1 at [31:16], element 2 at [15:0]
- out_valid  out  1  result held on out_data
- out_ready  in  1  consumer accepts the result
- out_data  out  48  result element r is row r·vector; element 0 at [47:32]
- busy  out  1  high in the ROW state

## Operation
- FSM states: IDLE, ROW, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture in_matrix and in_vector into operand registers, set row=0, go to ROW.
- ROW:
  - in_ready=0.
  - The dot unit evaluates operand row `row` against the captured vector. The result is written to result register `row` on the clock edge.
  - row increments 0→1→2. After the row=2 write, go to DONE.
  - The row counter never takes the value 3.
- DONE:
  - out_valid=1. out_data holds the result registers.
  - in_ready = out_ready.
  - If out_ready and in_valid: capture new operands, go to ROW with row=0. This is a back-to-back transfer.
  - If out_ready and no in_valid: go to IDLE.
  - If out_ready=0: hold, with out_data stable.
- Arithmetic (dot unit):
  - Each product is a signed 16×16 multiply truncated to its low 16 bits.
  - The two additions wrap modulo 2^16.
  - No saturation and no overflow flag.
- Reset:
  - Asserting system1000_rstn low at any time, including mid-ROW, forces IDLE.
  - A partially computed result is discarded, and the operand and result registers clear to 0.
- Reset values: in_ready=1 once reset is released, out_valid=0, out_data=0, busy=0.

## Timing
- Acceptance occurs at edge E0, when in_valid and in_ready are both high.
- Rows 0, 1 and 2 are written at edges E1, E2 and E3. out_valid rises after E3.
- Latency is 3 cycles from acceptance to out_valid.
- Maximum throughput is one operation per 4 cycles. A back-to-back transfer in DONE costs no extra IDLE cycle.
- in_matrix and in_vector are sampled only at acceptance. Changes during ROW have no effect.
- out_valid and out_data are registered outputs.
- in_ready is combinational from the state and out_ready. No other path runs combinationally from input to output.
- The dot unit is purely combinational, with a single-cycle path from the operand mux through the multipliers and adders to the result register.

## Structure
- Shared package mvs_pkg holds:
  - constants: ELEM_W=16, DIM=3
  - typedefs: elem_t (signed 16), row_t (3×elem_t), state_t (IDLE/ROW/DONE)
  - helper functions for row/element slicing consistent with the bit order above.
- Sub-module mvs_dot3 contains the combinational 3-element truncating multiply-and-sum. It has two 48-bit inputs and one signed 16-bit output, and is instantiated exactly once.
- The top level contains the FSM, the 2-bit row counter, the operand registers, the row mux, and three result registers.

## Test plan
- Identity matrix, vector (1,2,3) → out_data = 0x0001_0002_0003. out_valid rises 3 cycles after acceptance.
- Rows (-1,2,-3), (0,0,0) and (1,1,1), vector (4,5,6) → elements 0xFFF4, 0x0000, 0x000F.
- Every matrix element 0x0100, vector (0x0100,1,1):
  - Each row computes 0x0000 + 0x0100 + 0x0100 = 0x0200, because 0x0100×0x0100 truncates to 0.
  - Expected out_data = 0x0200_0200_0200.
- Backpressure: out_ready held low for 10 cycles in DONE → out_data constant, in_ready=0. A new in_valid is ignored until out_ready rises.
- Back-to-back: in_valid and out_ready both high in DONE → the second operation is accepted on the same edge, and its result appears 3 cycles later with no IDLE cycle in between.
- Reset asserted during row 1 of an operation → all outputs return to reset values immediately. After release, a fresh operation produces the correct result with no residue from the aborted one.
